// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the arbiter FSM state type.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} alu_arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU. Opcodes outside the defined set produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]     operand_a,
  input  logic [XLEN-1:0]     operand_b,
  input  logic [ALU_OP_W-1:0] alu_operation,
  output logic [XLEN-1:0]     alu_result,
  output logic                is_zero
);

  logic [4:0] shamt;
  assign shamt = operand_b[4:0];

  always_comb begin
    alu_result = '0;
    case (alu_operation)
      ALU_ADD:  alu_result = operand_a + operand_b;
      ALU_SUB:  alu_result = operand_a - operand_b;
      ALU_AND:  alu_result = operand_a & operand_b;
      ALU_OR:   alu_result = operand_a | operand_b;
      ALU_XOR:  alu_result = operand_a ^ operand_b;
      ALU_SLL:  alu_result = operand_a << shamt;
      ALU_SRL:  alu_result = operand_a >> shamt;
      ALU_SRA:  alu_result = $signed(operand_a) >>> shamt;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
      default:  alu_result = '0;
    endcase
  end

  assign is_zero = (alu_result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or above rr_ptr
// (wrapping) wins.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  always_comb begin : search
    logic found;
    int idx;
    logic [PTR_W-1:0] idx_w;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = PTR_W'(idx);
      if (!found && req[idx_w]) begin
        found        = 1'b1;
        grant[idx_w] = 1'b1;
        grant_idx    = idx_w;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters: grant, execute, then hold the
// result until the owning requester takes it.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*XLEN-1:0]      req_operand_a,
  input  logic [NUM_REQ*XLEN-1:0]      req_operand_b,
  input  logic [NUM_REQ*ALU_OP_W-1:0]  req_alu_operation,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [XLEN-1:0]              rsp_result,
  output logic                         rsp_is_zero,
  output logic                         rsp_error,
  output logic                         busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  alu_arb_state_t      state_reg, state_next;
  logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0]    owner_reg;
  logic [XLEN-1:0]     a_reg, b_reg;
  logic [ALU_OP_W-1:0] op_reg;
  logic [XLEN-1:0]     result_reg;
  logic                is_zero_reg;
  logic                error_reg;

  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                accept;
  logic [XLEN-1:0]     alu_result;
  logic                alu_is_zero;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  alu #(.XLEN(XLEN)) u_alu (
    .operand_a     (a_reg),
    .operand_b     (b_reg),
    .alu_operation (op_reg),
    .alu_result    (alu_result),
    .is_zero       (alu_is_zero)
  );

  // req_ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    req_ready   = '0;
    accept      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rst_n) req_ready = grant;
        if (|req_valid) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready[owner_reg]) begin
          state_next  = IDLE;
          rr_ptr_next = (owner_reg == PTR_W'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg   <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= ALU_ADD;
      result_reg  <= '0;
      is_zero_reg <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      if (accept) begin
        owner_reg <= grant_idx;
        a_reg     <= req_operand_a[grant_idx*XLEN +: XLEN];
        b_reg     <= req_operand_b[grant_idx*XLEN +: XLEN];
        op_reg    <= req_alu_operation[grant_idx*ALU_OP_W +: ALU_OP_W];
      end
      if (state_reg == EXEC) begin
        result_reg  <= alu_result;
        is_zero_reg <= alu_is_zero;
        error_reg   <= (op_reg > ALU_SLTU);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_valid
    assign rsp_valid[gi] = (state_reg == RESP) && (owner_reg == PTR_W'(gi));
  end

  assign rsp_result  = result_reg;
  assign rsp_is_zero = is_zero_reg;
  assign rsp_error   = error_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction-level model checked every cycle,
// plus directed transactions with hand-computed results.
module tb_alu_share_arbiter;

  localparam int N = 2;
  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_operand_a;
  logic [N*W-1:0] req_operand_b;
  logic [N*4-1:0] req_alu_operation;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_result;
  logic           rsp_is_zero;
  logic           rsp_error;
  logic           busy;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.NUM_REQ(N), .XLEN(W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_operand_a     (req_operand_a),
    .req_operand_b     (req_operand_b),
    .req_alu_operation (req_alu_operation),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_result        (rsp_result),
    .rsp_is_zero       (rsp_is_zero),
    .rsp_error         (rsp_error),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $signed(a) >>> b[4:0];
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Model: phase = cycles into the current operation (0 idle, 1 computing, 2 offering).
  int          m_phase = 0;
  int          m_ptr = 0;
  int          m_owner = 0;
  logic [31:0] m_pend = '0;
  logic [3:0]  m_pend_op = '0;
  logic [31:0] m_result = '0;
  logic        m_zero = 1'b0;
  logic        m_err = 1'b0;

  always @(negedge clk) begin : model_check
    int win;
    logic [N-1:0] e_ready;
    logic [N-1:0] e_rsp;
    win     = -1;
    e_ready = '0;
    e_rsp   = '0;
    if (!rst_n) begin
      m_phase  = 0;
      m_ptr    = 0;
      m_result = '0;
      m_zero   = 1'b0;
      m_err    = 1'b0;
    end else begin
      if (m_phase == 0) begin
        for (int k = 0; k < N; k++) begin
          if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        end
      end
      if (win >= 0) e_ready[win] = 1'b1;
      if (m_phase == 2) e_rsp[m_owner] = 1'b1;
    end
    chk("cyc_req_ready", 32'(req_ready), 32'(e_ready));
    chk("cyc_rsp_valid", 32'(rsp_valid), 32'(e_rsp));
    chk("cyc_rsp_result", rsp_result, m_result);
    chk("cyc_rsp_is_zero", 32'(rsp_is_zero), 32'(m_zero));
    chk("cyc_rsp_error", 32'(rsp_error), 32'(m_err));
    chk("cyc_busy", 32'(busy), 32'(rst_n && m_phase != 0));
    if (rst_n) begin
      if (m_phase == 0) begin
        if (win >= 0) begin
          m_owner   = win;
          m_pend_op = req_alu_operation[win*4 +: 4];
          m_pend    = alu_ref(req_operand_a[win*W +: W], req_operand_b[win*W +: W], m_pend_op);
          m_phase   = 1;
        end
      end else if (m_phase == 1) begin
        m_result = m_pend;
        m_zero   = (m_pend == 32'd0);
        m_err    = (m_pend_op > 4'd9);
        m_phase  = 2;
      end else if (rsp_ready[m_owner]) begin
        m_phase = 0;
        m_ptr   = (m_owner + 1) % N;
      end
    end
  end

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    req_operand_a[r*W +: W]   = a;
    req_operand_b[r*W +: W]   = b;
    req_alu_operation[r*4 +: 4] = op;
    req_valid[r]              = 1'b1;
  endtask

  task automatic wait_grant(input int r);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 30);
    chk("grant", 32'(req_ready), 32'(1) << r);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input int r, input logic [31:0] res, input logic z, input logic e);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid == '0 && n < 30);
    chk("rsp_owner", 32'(rsp_valid), 32'(1) << r);
    chk("rsp_result", rsp_result, res);
    chk("rsp_is_zero", 32'(rsp_is_zero), 32'(z));
    chk("rsp_error", 32'(rsp_error), 32'(e));
    $display("txn req%0d result %08h zero %0d err %0d", r, rsp_result, rsp_is_zero, rsp_error);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n             = 1'b0;
    req_valid         = '0;
    req_operand_a     = '0;
    req_operand_b     = '0;
    req_alu_operation = '0;
    rsp_ready         = '1;
    set_req(0, 32'd1, 32'd1, 4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_result", rsp_result, 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    rst_n     = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single add with exact latency
    set_req(0, 32'd5, 32'd7, 4'd0);
    #1;
    chk("add_ready_comb", 32'(req_ready), 32'd1);
    wait_grant(0);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("add_lat_exec", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("add_lat_resp", 32'(rsp_valid), 32'd1);
    chk("add_result", rsp_result, 32'd12);
    chk("add_zero", 32'(rsp_is_zero), 32'd0);
    $display("txn req0 result %08h zero %0d err %0d", rsp_result, rsp_is_zero, rsp_error);
    @(posedge clk); #1;

    // Contention from reset: 0, 1, 0
    rst_n = 1'b0;
    set_req(0, 32'd3, 32'd3, 4'd1);
    set_req(1, 32'h8000_0000, 32'd4, 4'd7);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    wait_grant(0);
    set_req(0, 32'd10, 32'd20, 4'd0);
    expect_rsp(0, 32'd0, 1'b1, 1'b0);
    wait_grant(1);
    req_valid[1] = 1'b0;
    expect_rsp(1, 32'hF800_0000, 1'b0, 1'b0);
    wait_grant(0);
    req_valid[0] = 1'b0;
    expect_rsp(0, 32'd30, 1'b0, 1'b0);

    // Backpressure on requester 0 while requester 1 waits
    rsp_ready = '0;
    set_req(0, 32'hFF, 32'h0F, 4'd2);
    wait_grant(0);
    req_valid[0] = 1'b0;
    set_req(1, 32'hF0F0, 32'hFFFF, 4'd4);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_result", rsp_result, 32'h0F);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = '1;
    @(negedge clk);
    chk("bp_release_cycle", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    chk("bp_released", 32'(rsp_valid), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'd2);
    $display("txn req0 result %08h zero %0d err %0d", rsp_result, rsp_is_zero, rsp_error);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    expect_rsp(1, 32'h0F0F, 1'b0, 1'b0);

    // Illegal opcode, then a legal one clears the error
    set_req(0, 32'd1, 32'd2, 4'hF);
    wait_grant(0);
    req_valid[0] = 1'b0;
    expect_rsp(0, 32'd0, 1'b1, 1'b1);
    set_req(1, 32'd1, 32'd2, 4'd3);
    wait_grant(1);
    req_valid[1] = 1'b0;
    expect_rsp(1, 32'd3, 1'b0, 1'b0);

    // Signed vs unsigned compare, subtract wrap
    set_req(0, 32'hFFFF_FFFF, 32'd1, 4'd8);
    wait_grant(0);
    req_valid[0] = 1'b0;
    expect_rsp(0, 32'd1, 1'b0, 1'b0);
    set_req(1, 32'hFFFF_FFFF, 32'd1, 4'd9);
    wait_grant(1);
    req_valid[1] = 1'b0;
    expect_rsp(1, 32'd0, 1'b1, 1'b0);
    set_req(0, 32'd0, 32'd1, 4'd1);
    wait_grant(0);
    req_valid[0] = 1'b0;
    expect_rsp(0, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Reset while requester 1 holds a response
    rsp_ready = 2'b01;
    set_req(1, 32'd2, 32'd3, 4'd0);
    wait_grant(1);
    repeat (2) @(negedge clk);
    chk("rst_pre_rsp_valid", 32'(rsp_valid), 32'd2);
    @(posedge clk); #1;
    set_req(0, 32'hC, 32'hA, 4'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_async_req_ready", 32'(req_ready), 32'd0);
    chk("rst_async_result", rsp_result, 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_zero", 32'(rsp_is_zero), 32'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    rsp_ready = '1;
    wait_grant(0);
    req_valid[0] = 1'b0;
    expect_rsp(0, 32'd8, 1'b0, 1'b0);
    wait_grant(1);
    req_valid[1] = 1'b0;
    expect_rsp(1, 32'd5, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
